// File: rtl/mem_resp_pkg.sv
// Shared definitions for the mem_responder slice: FSM encoding, latency bounds
// and the out-of-range address helper.
package mem_resp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int unsigned LAT_MIN = 1;
  localparam int unsigned LAT_MAX = 15;
  localparam int unsigned CNT_W   = 4;

  // True when the byte address lies beyond a 2**aw-word storage array.
  function automatic logic addr_out_of_range(input logic [31:0] addr, input int unsigned aw);
    return (addr >> (aw + 2)) != 32'd0;
  endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// Word-wide storage with per-byte-lane write enables and a registered read port.
// The read register is deliberately not reset so the array maps onto block RAM.
module mem_resp_ram #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [3:0]               we,
  input  logic [31:0]              wdata,
  input  logic                     re,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed LATENCY and byte-lane writes.
// Optional MEM_RESP_ERR_EN: out-of-range addresses flag RespErr instead of aliasing.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        Clk,
  input  logic        RstN,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWr,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  input  logic [7:0]  ReqMask,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [31:0] RespRData,
  output logic        RespErr
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_flag_q, rd_flag_d;
  logic             err_q, err_d;

  logic             accept;
  logic             addr_err;
  logic [AW-1:0]    word_idx;
  logic [3:0]       ram_we;
  logic             ram_re;
  logic [31:0]      ram_rdata;
  logic             unused_bits;

  assign accept   = ReqValid && (state_q == ST_IDLE);
  assign word_idx = ReqAddr[2 +: AW];

`ifdef MEM_RESP_ERR_EN
  assign addr_err = addr_out_of_range(ReqAddr, AW);
`else
  assign addr_err = 1'b0;
`endif

  assign unused_bits = ^{ReqAddr, ReqMask[7:4]};

  // Errored requests neither write nor read, so storage is untouched.
  assign ram_we = (accept && ReqWr && !addr_err) ? ReqMask[3:0] : 4'b0000;
  assign ram_re = accept && !ReqWr && !addr_err;

  mem_resp_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (Clk),
    .addr (word_idx),
    .we   (ram_we),
    .wdata(ReqWData),
    .re   (ram_re),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_flag_d = rd_flag_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (ReqValid) begin
          rd_flag_d = !ReqWr && !addr_err;
          err_d     = addr_err;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
            cnt_d   = '0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (RespReady) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_flag_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_flag_q <= rd_flag_d;
      err_q     <= err_d;
    end
  end

  // The RAM read register only changes at a read accept, so gating it with
  // rd_flag_q keeps RespRData stable through WAIT/RESP and zero for writes.
  assign ReqReady  = (state_q == ST_IDLE);
  assign RespValid = (state_q == ST_RESP);
  assign RespRData = rd_flag_q ? ram_rdata : 32'd0;
  assign RespErr   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a LATENCY=1 and a LATENCY=4 instance driven from a
// vector table through a scoreboard queue, plus reset and back-to-back sequences.
module tb_mem_responder;

`ifdef MEM_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    int          dut;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  mask;
    int          hold;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_wr     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [7:0]  req_mask   [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.DEPTH(1024), .LATENCY(1)) u_dut_l1 (
    .Clk(clk), .RstN(rst_n[0]),
    .ReqValid(req_valid[0]), .ReqReady(req_ready[0]), .ReqWr(req_wr[0]),
    .ReqAddr(req_addr[0]), .ReqWData(req_wdata[0]), .ReqMask(req_mask[0]),
    .RespValid(resp_valid[0]), .RespReady(resp_ready[0]),
    .RespRData(resp_rdata[0]), .RespErr(resp_err[0])
  );

  mem_responder #(.DEPTH(1024), .LATENCY(4)) u_dut_l4 (
    .Clk(clk), .RstN(rst_n[1]),
    .ReqValid(req_valid[1]), .ReqReady(req_ready[1]), .ReqWr(req_wr[1]),
    .ReqAddr(req_addr[1]), .ReqWData(req_wdata[1]), .ReqMask(req_mask[1]),
    .RespValid(resp_valid[1]), .RespReady(resp_ready[1]),
    .RespRData(resp_rdata[1]), .RespErr(resp_err[1])
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Issue one request, score its response, optionally stall RespReady, then retire it.
  task automatic txn(input vec_t v);
    int          d;
    int          n;
    int          acc;
    int          lat;
    exp_t        e;
    logic [31:0] held;
    d = v.dut;
    @(negedge clk);
    req_valid[d]  = 1'b1;
    req_wr[d]     = v.wr;
    req_addr[d]   = v.addr;
    req_wdata[d]  = v.wdata;
    req_mask[d]   = v.mask;
    resp_ready[d] = 1'b0;
    n = 0;
    while (!req_ready[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid[d] = 1'b0;
      return;
    end
    acc = cyc + 1;
    sb.push_back('{rdata: v.exp_rdata, err: v.exp_err, lat: (d == 0) ? 1 : 4});
    @(negedge clk);
    req_valid[d] = 1'b0;
    chk("busy_req_ready", 32'(req_ready[d]), 32'd0);
    n = 0;
    while (!resp_valid[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    if (!resp_valid[d]) begin
      chk("resp_timeout", 32'd0, 32'd1);
      return;
    end
    lat = cyc - acc + 1;
    chk("rdata", resp_rdata[d], e.rdata);
    chk("err", 32'(resp_err[d]), 32'(e.err));
    chk("latency", 32'(lat), 32'(e.lat));
    held = resp_rdata[d];
    repeat (v.hold) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid[d]), 32'd1);
      chk("hold_rdata", resp_rdata[d], held);
      chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
    end
    resp_ready[d] = 1'b1;
    @(negedge clk);
    resp_ready[d] = 1'b0;
    chk("exit_resp_valid", 32'(resp_valid[d]), 32'd0);
    chk("exit_req_ready", 32'(req_ready[d]), 32'd1);
    $display("txn dut=%0d wr=%0d addr=%h wdata=%h mask=%h -> rdata=%h err=%0d lat=%0d",
             d, v.wr, v.addr, v.wdata, v.mask, held, e.err, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc_e[$];
    int   exit_e[$];
    vec_t rv;

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_wr[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; req_mask[d] = '0; resp_ready[d] = 1'b0;
    end

    // Vector table: {dut, wr, addr, wdata, mask, hold, exp_rdata, exp_err}
    vecs.push_back('{0, 1'b1, 32'h10,   32'h12345678, 8'h0F, 0, 32'h0,        1'b0});
    vecs.push_back('{0, 1'b0, 32'h10,   32'h0,        8'h00, 0, 32'h12345678, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h10,   32'hAB000000, 8'h08, 0, 32'h0,        1'b0});
    vecs.push_back('{0, 1'b0, 32'h13,   32'h0,        8'h00, 0, 32'hAB345678, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h10,   32'hFFFFFFFF, 8'hF0, 0, 32'h0,        1'b0});
    vecs.push_back('{0, 1'b0, 32'h10,   32'h0,        8'h00, 0, 32'hAB345678, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h14,   32'h11223344, 8'hFF, 0, 32'h0,        1'b0});
    vecs.push_back('{0, 1'b1, 32'h14,   32'h000000EE, 8'h01, 0, 32'h0,        1'b0});
    vecs.push_back('{0, 1'b0, 32'h16,   32'h0,        8'h00, 1, 32'h112233EE, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h0,    32'h55AA55AA, 8'h0F, 0, 32'h0,        1'b0});
    vecs.push_back('{0, 1'b1, 32'h1000, 32'h99999999, 8'h0F, 0, 32'h0,        ERR_EN});
    vecs.push_back('{0, 1'b0, 32'h0,    32'h0,        8'h00, 0,
                     ERR_EN ? 32'h55AA55AA : 32'h99999999, 1'b0});
    vecs.push_back('{0, 1'b0, 32'h1000, 32'h0,        8'h00, 0,
                     ERR_EN ? 32'h0 : 32'h99999999, ERR_EN});
    vecs.push_back('{1, 1'b1, 32'h10,   32'hCAFEF00D, 8'h0F, 0, 32'h0,        1'b0});
    vecs.push_back('{1, 1'b0, 32'h10,   32'h0,        8'h00, 3, 32'hCAFEF00D, 1'b0});
    vecs.push_back('{1, 1'b1, 32'h10,   32'h00BEEF00, 8'h06, 0, 32'h0,        1'b0});
    vecs.push_back('{1, 1'b0, 32'h10,   32'h0,        8'h00, 0, 32'hCABEEF0D, 1'b0});

    // Reset state
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
      chk("rst_resp_rdata", resp_rdata[d], 32'd0);
      chk("rst_resp_err", 32'(resp_err[d]), 32'd0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
    $display("reset released at cycle %0d", cyc);

    for (int i = 0; i < vecs.size(); i++) txn(vecs[i]);

    // Reset asserted while a write waits in WAIT on the LATENCY=4 instance.
    @(negedge clk);
    req_valid[1] = 1'b1; req_wr[1] = 1'b1; req_addr[1] = 32'h20;
    req_wdata[1] = 32'hDEADBEEF; req_mask[1] = 8'h0F;
    chk("rstw_idle_ready", 32'(req_ready[1]), 32'd1);
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("rstw_in_wait_valid", 32'(resp_valid[1]), 32'd0);
    chk("rstw_in_wait_ready", 32'(req_ready[1]), 32'd0);
    rst_n[1] = 1'b0;
    #1;
    chk("rstw_async_valid", 32'(resp_valid[1]), 32'd0);
    chk("rstw_async_rdata", resp_rdata[1], 32'd0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    @(negedge clk);
    chk("rstw_release_ready", 32'(req_ready[1]), 32'd1);
    repeat (5) @(negedge clk);
    chk("rstw_no_stray_resp", 32'(resp_valid[1]), 32'd0);
    $display("txn dut=1 reset during WAIT of write addr=00000020 wdata=deadbeef");
    rv = '{1, 1'b0, 32'h20, 32'h0, 8'h00, 0, 32'hDEADBEEF, 1'b0};
    txn(rv);

    // ReqValid held across RESP with RespReady=1 on the LATENCY=1 instance.
    @(negedge clk);
    req_valid[0] = 1'b1; req_wr[0] = 1'b0; req_addr[0] = 32'h10;
    req_mask[0] = 8'h00; resp_ready[0] = 1'b1;
    for (int i = 0; i < 20 && acc_e.size() < 2; i++) begin
      if (req_ready[0]) acc_e.push_back(cyc + 1);
      if (resp_valid[0]) exit_e.push_back(cyc + 1);
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    if (acc_e.size() < 2 || exit_e.size() < 1) begin
      chk("b2b_accepts_seen", 32'(acc_e.size()), 32'd2);
    end else begin
      chk("b2b_first_exit", 32'(exit_e[0]), 32'(acc_e[0] + 1));
      chk("b2b_second_accept", 32'(acc_e[1]), 32'(exit_e[0] + 1));
      chk("b2b_resp_valid", 32'(resp_valid[0]), 32'd1);
      chk("b2b_rdata", resp_rdata[0], 32'hAB345678);
      $display("txn dut=0 back-to-back read addr=00000010 accepts=%0d,%0d exit=%0d",
               acc_e[0], acc_e[1], exit_e[0]);
    end
    @(negedge clk);
    resp_ready[0] = 1'b0;
    chk("b2b_final_ready", 32'(req_ready[0]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024: storage size in 32-bit words, a power of two.
REQ-002 SHALL have parameter LATENCY, default 1: cycles from request accept to RespValid, legal range 1..15.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port RstN, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port ReqValid, input, 1 bit: the initiator presents a request.
REQ-006 SHALL have port ReqReady, output, 1 bit: the responder can accept a request.
REQ-007 SHALL have port ReqWr, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port ReqAddr, input, 32 bits: byte address; bits [1:0] are ignored (word-aligned access).
REQ-009 SHALL have port ReqWData, input, 32 bits: write data, already lane-positioned.
REQ-010 SHALL have port ReqMask, input, 8 bits: byte-lane enables; bit3 maps to [31:24], bit2 to [23:16], bit1 to [15:8], bit0 to [7:0]; bits [7:4] are ignored.
REQ-011 SHALL have port RespValid, output, 1 bit: a response is held.
REQ-012 SHALL have port RespReady, input, 1 bit: the initiator takes the response.
REQ-013 SHALL have port RespRData, output, 32 bits: the full aligned word for reads; 0 for writes.
REQ-014 SHALL have port RespErr, output, 1 bit: error flag (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and RESP; ReqReady = 1 only in IDLE; RespValid = 1 only in RESP.
REQ-016 SHALL accept a request on a rising edge where ReqValid && ReqReady; IDLE goes to RESP if LATENCY==1, else to WAIT with counter = LATENCY-1.
REQ-017 SHALL decrement the counter each cycle in WAIT and move to RESP on the edge where the counter reaches 0; RespValid first rises LATENCY edges after accept.
REQ-018 SHALL commit a write at the accept edge, updating only lanes whose mask bit is 1; ReqMask[3:0]==0 is a no-op write with a normal response.
REQ-019 SHALL sample read data at the accept edge into the response register, so RespRData is stable throughout WAIT and RESP.
REQ-020 SHALL hold RespRData and RespErr constant while RespValid && !RespReady.
REQ-021 SHALL return RESP to IDLE on an edge where RespReady = 1; ReqReady rises the following cycle, with no same-cycle response/accept overlap.
REQ-022 SHALL set minimum request spacing to LATENCY+1 cycles.
REQ-023 SHALL form the word index as ReqAddr[2 +: log2(DEPTH)]; without the macro, higher address bits alias (wrap-around).
REQ-024 SHALL ignore ReqValid outside IDLE, and ignore RespReady outside RESP.

Reset
REQ-025 SHALL, while RstN = 0, immediately force: state IDLE, counter 0, RespValid 0, RespRData 0, RespErr 0; ReqReady is 1 once RstN deasserts.
REQ-026 SHALL drop any in-flight response if reset asserts mid-operation; a write committed at accept stays committed.
REQ-027 SHALL leave storage contents unaffected by reset.

Configuration
REQ-028 SHALL, with MEM_RESP_ERR_EN defined, treat ReqAddr >= DEPTH*4 as an error: the write is suppressed, RespRData = 0, RespErr = 1, and timing is unchanged.
REQ-029 SHALL, without MEM_RESP_ERR_EN, tie RespErr to 0 and alias out-of-range addresses per REQ-023.

Structure
REQ-030 SHALL place the FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2) and the LATENCY bounds in shared package mem_resp_pkg.
REQ-031 SHALL put storage in one sub-module, mem_resp_ram: a DEPTH x 32 array with a 4-bit per-lane write enable, and a registered read port with its enable driven at accept.

Verification
REQ-032 SHALL cover: LATENCY=1, write 0x12345678 to addr 0x10 with mask 0x0F, then read 0x10 -> RespValid one edge after accept, RespRData=0x12345678, RespErr=0.
REQ-033 SHALL cover: write 0xAB000000 to 0x10 with mask 0x08, then read 0x13 -> 0xAB345678.
REQ-034 SHALL cover: LATENCY=4, read accepted at edge N -> RespValid rises at edge N+4; hold RespReady=0 for 3 cycles -> data stable and ReqReady=0 throughout.
REQ-035 SHALL cover: DEPTH=1024, MEM_RESP_ERR_EN defined, write to 0x1000 -> RespErr=1, and 0x0000 is unchanged; macro undefined -> the write lands at 0x0000.
REQ-036 SHALL cover: RstN pulled low in WAIT after a write of 0xDEADBEEF to 0x20 -> RespValid=0 and ReqReady=1 after release; a later read of 0x20 -> 0xDEADBEEF.
REQ-037 SHALL cover: ReqValid held high across RESP with RespReady=1 -> the second accept occurs exactly one cycle after the RESP exit edge.
